trace_capture_fifo: RTL and testbench



---
 rtl/trace_capture_fifo_pkg.sv | 20 ++
 rtl/trace_capture_fifo_fifo.sv | 73 +++++++
 rtl/trace_capture_fifo.sv | 153 +++++++++++++++
 tb/tb_trace_capture_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_fifo_pkg.sv
// Shared definitions for the trace capture path: stream FSM states and sizing constants.
// Optional feature macro used by the top: TRACE_DROP_COUNT_EN.
package trace_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } trace_state_e;

    localparam int unsigned TRACE_WIDTH_DEFAULT = 96;
    localparam int unsigned BYTES_PER_ENTRY     = TRACE_WIDTH_DEFAULT / 8;
    localparam int unsigned DROP_CNT_W          = 16;

    // Byte-index width; never zero so single-byte entries still get a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_capture_fifo_fifo.sv
// Synchronous single-clock FIFO with registered count/full/empty and a combinational head read.
module trace_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A push while full is only legal when the head leaves in the same cycle.
    always_comb begin
        do_push = push_i && (!full_q || pop_i);
        do_pop  = pop_i && !empty_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/trace_capture_fifo.sv
// Captures snapshot-bus entries into a FIFO and serializes them LSB-byte first, closing with out_last.
// Define TRACE_DROP_COUNT_EN to add the saturating drop_count port.
module trace_capture_fifo
    import trace_pkg::*;
#(
    parameter int unsigned WIDTH = BYTES_PER_ENTRY * 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             capture_valid,
    input  logic [WIDTH-1:0] capture_data,
    input  logic             halt,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done,
    output logic             overflow
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned IW    = idx_width(BYTES);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    trace_state_e     state_q;

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic             ser_valid_q;
    logic             ser_valid_d;
    logic             overflow_q;

    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic             out_valid_w;
    logic             out_last_w;
    logic             accept;
    logic             ser_last;
    logic             load;
    logic             push_req;
    logic             push;
    logic             drop;

    trace_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (capture_data),
        .pop_i   (load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        out_valid_w = ser_valid_q && (state_q != DONE);
        ser_last    = (idx_q == LAST_IDX);
        accept      = out_valid_w && out_ready;
        out_last_w  = out_valid_w && (state_q == DRAIN) && (fifo_count == '0) && ser_last;
        // Refill on the same edge the final byte leaves, so entries stream without a bubble.
        load        = !fifo_empty && (!ser_valid_q || (accept && ser_last));
        push_req    = (state_q == CAPTURE) && capture_valid;
        push        = push_req && (!fifo_full || load);
        drop        = push_req && !push;
    end

    always_comb begin
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        ser_valid_d = ser_valid_q;
        if (load) begin
            shreg_d     = fifo_rdata;
            idx_d       = '0;
            ser_valid_d = 1'b1;
        end else if (accept) begin
            shreg_d = shreg_q >> 8;
            if (ser_last) begin
                idx_d       = '0;
                ser_valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q     <= '0;
            idx_q       <= '0;
            ser_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            ser_valid_q <= ser_valid_d;
            overflow_q  <= overflow_q | drop;
        end
    end

    // DRAIN exits on the flagged final byte, or at once when nothing was ever buffered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CAPTURE;
        end else begin
            case (state_q)
                CAPTURE: if (halt) state_q <= DRAIN;
                DRAIN: begin
                    if ((!ser_valid_q && fifo_empty) || (accept && out_last_w)) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= CAPTURE;
            endcase
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign out_valid = out_valid_w;
    assign out_data  = shreg_q[7:0];
    assign out_last  = out_last_w;
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Directed self-checking bench for trace_capture_fifo; drop_count checks only with TRACE_DROP_COUNT_EN.
module tb_trace_capture_fifo;

    logic        clock;
    logic        reset;
    logic        capture_valid;
    logic [95:0] capture_data;
    logic        halt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        out_last;
    logic        done;
    logic        overflow;
`ifdef TRACE_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned xfers  = 0;
    int unsigned lasts  = 0;
    logic [7:0]  exp_q[$];
    logic        stall_prev = 1'b0;
    logic [7:0]  held_data  = '0;
    logic        held_last  = 1'b0;

    trace_capture_fifo #(
        .WIDTH (96),
        .DEPTH (64)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .capture_valid (capture_valid),
        .capture_data  (capture_data),
        .halt          (halt),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .done          (done),
        .overflow      (overflow)
`ifdef TRACE_DROP_COUNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [7:0] base);
        logic [95:0] e;
        for (int k = 0; k < 12; k++) e[8*k +: 8] = base + 8'(k);
        return e;
    endfunction

    task automatic push_exp(input logic [95:0] e);
        for (int k = 0; k < 12; k++) exp_q.push_back(e[8*k +: 8]);
    endtask

    // One clock: score any transfer and stall stability, then advance to #1 past the edge.
    task automatic cyc();
        logic [7:0] eb;
        if (stall_prev && out_valid) begin
            chk("hold_data", out_data, held_data);
            chk("hold_last", out_last, held_last);
        end
        if (out_valid && out_ready && !reset) begin
            xfers++;
            if (exp_q.size() == 0) begin
                chk("extra_byte", out_valid, 1'b0);
            end else begin
                eb = exp_q.pop_front();
                chk("byte", out_data, eb);
                chk("last_flag", out_last, (exp_q.size() == 0));
                if (out_last) lasts++;
            end
        end
        stall_prev = out_valid && !out_ready && !reset;
        held_data  = out_data;
        held_last  = out_last;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        capture_valid = 1'b0;
        halt          = 1'b0;
        out_ready     = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        exp_q.delete();
        xfers = 0;
        lasts = 0;
    endtask

    task automatic drain(input bit toggle, input int unsigned bound);
        int unsigned n = 0;
        while (!done && n < bound) begin
            out_ready = toggle ? !out_ready : 1'b1;
            cyc();
            n++;
        end
        chk("drain_done", done, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        capture_valid = 1'b0;
        capture_data  = '0;
        halt          = 1'b0;
        out_ready     = 1'b0;
        do_reset();

        // Reset values
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
`ifdef TRACE_DROP_COUNT_EN
        chk("rst_drops", drop_count, 16'h0);
`endif

        // Single snapshot with halting capture: bytes 00..0B at N+2..N+13
        capture_valid = 1'b1;
        capture_data  = 96'h0B0A_0908_0706_0504_0302_0100;
        halt          = 1'b1;
        out_ready     = 1'b1;
        push_exp(capture_data);
        cyc();
        capture_valid = 1'b0;
        chk("t1_n1_valid", out_valid, 1'b0);
        cyc();
        for (int k = 0; k < 12; k++) begin
            chk("t1_valid", out_valid, 1'b1);
            chk("t1_data", out_data, 8'(k));
            chk("t1_last", out_last, (k == 11));
            cyc();
        end
        chk("t1_done", done, 1'b1);
        chk("t1_idle", out_valid, 1'b0);

        // Halt with nothing buffered, then captures after done
        do_reset();
        halt = 1'b1;
        cyc();
        chk("t3_done_n1", done, 1'b0);
        chk("t3_valid_n1", out_valid, 1'b0);
        cyc();
        chk("t3_done_n2", done, 1'b1);
        chk("t3_valid_n2", out_valid, 1'b0);
        chk("t3_last_n2", out_last, 1'b0);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            capture_valid = 1'b1;
            capture_data  = mk(8'hE0);
            cyc();
            chk("t6_no_out", out_valid, 1'b0);
        end
        capture_valid = 1'b0;
        cyc();
        cyc();
        chk("t6_done_held", done, 1'b1);
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_ovf", overflow, 1'b0);
`ifdef TRACE_DROP_COUNT_EN
        chk("t6_drops", drop_count, 16'h0);
`endif

        // Overflow: serializer holds one entry and the FIFO 64, so the 66th capture drops
        do_reset();
        for (int i = 0; i < 66; i++) begin
            if (i == 65) chk("t2_ovf_before", overflow, 1'b0);
            capture_valid = 1'b1;
            capture_data  = mk(8'(i));
            if (i < 65) push_exp(mk(8'(i)));
            cyc();
        end
        capture_valid = 1'b0;
        chk("t2_ovf", overflow, 1'b1);
`ifdef TRACE_DROP_COUNT_EN
        chk("t2_drops", drop_count, 16'h1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) cyc();
        // Final byte of entry 0 leaves as a capture arrives: push on full with pop
        capture_valid = 1'b1;
        capture_data  = mk(8'hA0);
        push_exp(mk(8'hA0));
        cyc();
        capture_valid = 1'b0;
        chk("t2_pushpop_ovf", overflow, 1'b1);
`ifdef TRACE_DROP_COUNT_EN
        chk("t2_pushpop_drops", drop_count, 16'h1);
`endif
        halt = 1'b1;
        drain(1'b0, 1200);
        chk("t2_bytes", xfers, 66 * 12);
        chk("t2_lasts", lasts, 1);
        chk("t2_sb_empty", exp_q.size(), 0);

        // out_ready toggling over three entries
        do_reset();
        for (int i = 0; i < 3; i++) begin
            capture_valid = 1'b1;
            capture_data  = mk(8'(8'h30 + 8'(i * 32)));
            push_exp(capture_data);
            halt = (i == 2);
            cyc();
        end
        capture_valid = 1'b0;
        drain(1'b1, 200);
        chk("t4_bytes", xfers, 36);
        chk("t4_lasts", lasts, 1);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Reset after byte 5 of an entry, then a fresh entry streams from byte 0
        do_reset();
        out_ready     = 1'b1;
        capture_valid = 1'b1;
        capture_data  = mk(8'h10);
        push_exp(capture_data);
        cyc();
        capture_valid = 1'b0;
        for (int n = 0; n < 40 && xfers < 6; n++) cyc();
        chk("t5_six_bytes", xfers, 6);
        out_ready = 1'b0;
        reset     = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        xfers = 0;
        lasts = 0;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_ovf", overflow, 1'b0);
        chk("t5_last", out_last, 1'b0);
        chk("t5_done", done, 1'b0);
        out_ready     = 1'b1;
        capture_valid = 1'b1;
        capture_data  = mk(8'h20);
        halt          = 1'b1;
        push_exp(capture_data);
        cyc();
        capture_valid = 1'b0;
        drain(1'b0, 40);
        chk("t5_bytes", xfers, 12);
        chk("t5_lasts", lasts, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
